// File: rtl/ex_mem_wb_stage.sv
// Execute / memory / write-back stage of the non-pipelined RV32I core.
// Takes one decoded bundle, executes it, performs any data-memory access,
// then writes the register file and hands PC_NEXT back to fetch.
module ex_mem_wb_stage #(
    parameter int unsigned DM_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ID_EX_A,
    input  logic [31:0] ID_EX_B,
    input  logic [31:0] ID_EX_IMM,
    input  logic [31:0] ID_EX_IR,
    input  logic [31:0] ID_EX_PC,
    input  logic [31:0] ID_EX_NPC,
    input  logic        ID_EX_VALID,
    output logic        ID_EX_READY,
    output logic        DM_REQ,
    output logic        DM_WE,
    output logic [31:0] DM_ADDR,
    output logic [31:0] DM_WDATA,
    output logic [3:0]  DM_BE,
    input  logic [31:0] DM_RDATA,
    input  logic        DM_ACK,
    output logic        WB_WE,
    output logic [4:0]  WB_RW_addr,
    output logic [31:0] WB_WR1,
    output logic [31:0] PC_NEXT,
    output logic        PC_NEXT_VALID,
    output logic [1:0]  EXC
);
    typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    state_t state, state_nxt;
    logic        ready_q;
    logic [31:0] a_q, b_q, imm_q, ir_q, pc_q, npc_q;
    logic [31:0] addr_q, wdata_q, cnt_q;
    logic [3:0]  be_q;
    logic [1:0]  off_q;
    logic        dm_we_q, ld_wr_q;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] op2, alu_res, ea, result, target, ld_word, ld_val, wdata;
    logic [3:0]  be;
    logic [1:0]  exc;
    logic        writes, illegal, misaligned, is_mem, go_mem, taken, timeout_hit, mem_active;
    logic        unused_ir;

    assign opcode      = ir_q[6:0];
    assign rd          = ir_q[11:7];
    assign f3          = ir_q[14:12];
    assign unused_ir   = ^{ir_q[31], ir_q[29:15]};
    assign ea          = a_q + imm_q;
    assign timeout_hit = (DM_TIMEOUT != 0) && (cnt_q == DM_TIMEOUT - 1);
    assign mem_active  = (state == MEM);

    assign ID_EX_READY = ready_q;
    assign DM_REQ      = mem_active;
    assign DM_WE       = mem_active & dm_we_q;
    assign DM_ADDR     = mem_active ? addr_q  : '0;
    assign DM_WDATA    = mem_active ? wdata_q : '0;
    assign DM_BE       = mem_active ? be_q    : '0;

    // ALU for OP / OP-IMM; second operand is rs2 for OP, immediate otherwise
    always_comb begin
        op2 = (opcode == OPC_OP) ? b_q : imm_q;
        case (f3)
            3'b000:  alu_res = (opcode == OPC_OP && ir_q[30]) ? a_q - op2 : a_q + op2;
            3'b001:  alu_res = a_q << op2[4:0];
            3'b010:  alu_res = {31'b0, $signed(a_q) < $signed(op2)};
            3'b011:  alu_res = {31'b0, a_q < op2};
            3'b100:  alu_res = a_q ^ op2;
            3'b101:  alu_res = ir_q[30] ? $unsigned($signed(a_q) >>> op2[4:0]) : a_q >> op2[4:0];
            3'b110:  alu_res = a_q | op2;
            default: alu_res = a_q & op2;
        endcase
    end

    // Instruction decode: rd result, next PC, memory access shape, exceptions
    always_comb begin
        result     = '0;
        target     = npc_q;
        writes     = 1'b0;
        illegal    = 1'b0;
        misaligned = 1'b0;
        is_mem     = 1'b0;
        taken      = 1'b0;
        case (f3[1:0])
            2'b00:   begin be = 4'b0001 << ea[1:0];               wdata = {4{b_q[7:0]}};  end
            2'b01:   begin be = ea[1] ? 4'b1100 : 4'b0011;       wdata = {2{b_q[15:0]}}; end
            default: begin be = 4'b1111;                          wdata = b_q;            end
        endcase
        case (opcode)
            OPC_OP, OPC_OPIMM: begin result = alu_res;       writes = 1'b1; end
            OPC_LUI:           begin result = imm_q;         writes = 1'b1; end
            OPC_AUIPC:         begin result = pc_q + imm_q;  writes = 1'b1; end
            OPC_JAL: begin
                result = npc_q;
                writes = 1'b1;
                target = pc_q + imm_q;
            end
            OPC_JALR: begin
                result = npc_q;
                writes = 1'b1;
                target = {ea[31:1], 1'b0};
            end
            OPC_BRANCH: begin
                case (f3)
                    3'b000:  taken = (a_q == b_q);
                    3'b001:  taken = (a_q != b_q);
                    3'b100:  taken = ($signed(a_q) <  $signed(b_q));
                    3'b101:  taken = ($signed(a_q) >= $signed(b_q));
                    3'b110:  taken = (a_q <  b_q);
                    3'b111:  taken = (a_q >= b_q);
                    default: illegal = 1'b1;
                endcase
                if (taken) target = pc_q + imm_q;
            end
            OPC_LOAD, OPC_STORE: begin
                is_mem = 1'b1;
                writes = (opcode == OPC_LOAD);
                case (f3)
                    3'b000:  ;
                    3'b001:  misaligned = ea[0];
                    3'b010:  misaligned = |ea[1:0];
                    3'b100:  illegal = (opcode == OPC_STORE);
                    3'b101:  begin illegal = (opcode == OPC_STORE); misaligned = ea[0] & ~illegal; end
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
        exc    = illegal ? 2'd1 : (misaligned ? 2'd2 : 2'd0);
        go_mem = is_mem && (exc == 2'd0);
    end

    // Select and extend the addressed lane of the returned load word
    always_comb begin
        ld_word = DM_RDATA >> {off_q, 3'b000};
        case (f3)
            3'b000:  ld_val = {{24{ld_word[7]}}, ld_word[7:0]};
            3'b001:  ld_val = {{16{ld_word[15]}}, ld_word[15:0]};
            3'b100:  ld_val = {24'b0, ld_word[7:0]};
            3'b101:  ld_val = {16'b0, ld_word[15:0]};
            default: ld_val = ld_word;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ID_EX_VALID && ready_q) state_nxt = EXEC;
            EXEC:    state_nxt = go_mem ? MEM : WB;
            MEM:     if (DM_ACK || timeout_hit) state_nxt = WB;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, bundle capture, memory request latch and write-back outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            ready_q       <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            imm_q         <= '0;
            ir_q          <= '0;
            pc_q          <= '0;
            npc_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            off_q         <= '0;
            dm_we_q       <= 1'b0;
            ld_wr_q       <= 1'b0;
            cnt_q         <= '0;
            WB_WE         <= 1'b0;
            WB_RW_addr    <= '0;
            WB_WR1        <= '0;
            PC_NEXT       <= '0;
            PC_NEXT_VALID <= 1'b0;
            EXC           <= '0;
        end else begin
            state         <= state_nxt;
            ready_q       <= (state_nxt == IDLE);
            WB_WE         <= 1'b0;
            PC_NEXT_VALID <= 1'b0;
            EXC           <= '0;
            case (state)
                IDLE: begin
                    if (ID_EX_VALID && ready_q) begin
                        a_q   <= ID_EX_A;
                        b_q   <= ID_EX_B;
                        imm_q <= ID_EX_IMM;
                        ir_q  <= ID_EX_IR;
                        pc_q  <= ID_EX_PC;
                        npc_q <= ID_EX_NPC;
                    end
                end
                EXEC: begin
                    addr_q  <= {ea[31:2], 2'b00};
                    off_q   <= ea[1:0];
                    be_q    <= be;
                    wdata_q <= wdata;
                    dm_we_q <= (opcode == OPC_STORE);
                    ld_wr_q <= (opcode == OPC_LOAD) && (rd != 5'd0);
                    cnt_q   <= '0;
                    // Non-memory instructions complete here, so WB outputs load on this edge
                    if (!go_mem) begin
                        WB_WE         <= writes && (rd != 5'd0) && (exc == 2'd0);
                        WB_RW_addr    <= rd;
                        WB_WR1        <= result;
                        PC_NEXT       <= target;
                        PC_NEXT_VALID <= 1'b1;
                        EXC           <= exc;
                    end
                end
                MEM: begin
                    if (DM_ACK) begin
                        WB_WE         <= ld_wr_q;
                        WB_RW_addr    <= rd;
                        WB_WR1        <= ld_val;
                        PC_NEXT       <= npc_q;
                        PC_NEXT_VALID <= 1'b1;
                    end else if (timeout_hit) begin
                        WB_RW_addr    <= rd;
                        PC_NEXT       <= npc_q;
                        PC_NEXT_VALID <= 1'b1;
                        EXC           <= 2'd3;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_mem_wb_stage.sv
// Randomized self-checking bench for ex_mem_wb_stage against an instruction-level model.
module tb_ex_mem_wb_stage;
    localparam int unsigned TMO = 5;

    logic        clk, rst;
    logic [31:0] ID_EX_A, ID_EX_B, ID_EX_IMM, ID_EX_IR, ID_EX_PC, ID_EX_NPC;
    logic        ID_EX_VALID, ID_EX_READY;
    logic        DM_REQ, DM_WE, DM_ACK;
    logic [31:0] DM_ADDR, DM_WDATA, DM_RDATA;
    logic [3:0]  DM_BE;
    logic        WB_WE, PC_NEXT_VALID;
    logic [4:0]  WB_RW_addr;
    logic [31:0] WB_WR1, PC_NEXT;
    logic [1:0]  EXC;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        bit          mem;
        bit          st;
        int          cyc;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          wr;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [31:0] pcn;
        logic [1:0]  exc;
    } exp_t;

    ex_mem_wb_stage #(.DM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .ID_EX_A(ID_EX_A), .ID_EX_B(ID_EX_B), .ID_EX_IMM(ID_EX_IMM), .ID_EX_IR(ID_EX_IR),
        .ID_EX_PC(ID_EX_PC), .ID_EX_NPC(ID_EX_NPC), .ID_EX_VALID(ID_EX_VALID), .ID_EX_READY(ID_EX_READY),
        .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA), .DM_BE(DM_BE),
        .DM_RDATA(DM_RDATA), .DM_ACK(DM_ACK),
        .WB_WE(WB_WE), .WB_RW_addr(WB_RW_addr), .WB_WR1(WB_WR1),
        .PC_NEXT(PC_NEXT), .PC_NEXT_VALID(PC_NEXT_VALID), .EXC(EXC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [2:0] f3, input bit sub, input bit arith,
                                             input logic [31:0] x, input logic [31:0] y);
        logic [4:0] s;
        s = y[4:0];
        case (f3)
            3'd0:    return sub ? x - y : x + y;
            3'd1:    return x << s;
            3'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3:    return (x < y) ? 32'd1 : 32'd0;
            3'd4:    return x ^ y;
            3'd5:    return arith ? $unsigned($signed(x) >>> s) : x >> s;
            3'd6:    return x | y;
            default: return x & y;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                   input logic [31:0] ir, input logic [31:0] pc, input int d,
                                   input logic [31:0] rdata);
        exp_t e;
        logic [31:0] npc, ea, raw;
        logic [2:0]  f3;
        logic [1:0]  off;
        bit          taken;
        int          sz;
        npc = pc + 32'd4;
        f3  = ir[14:12];
        ea  = a + imm;
        off = ea[1:0];
        e.mem = 0; e.st = 0; e.cyc = 0; e.addr = '0; e.be = '0; e.wdata = '0;
        e.wr = 0; e.rd = ir[11:7]; e.val = '0; e.pcn = npc; e.exc = 2'd0;
        sz = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        case (ir[6:0])
            7'h33: begin e.wr = 1; e.val = alu_ref(f3, ir[30], ir[30], a, b); end
            7'h13: begin e.wr = 1; e.val = alu_ref(f3, 1'b0, ir[30], a, imm); end
            7'h37: begin e.wr = 1; e.val = imm; end
            7'h17: begin e.wr = 1; e.val = pc + imm; end
            7'h6F: begin e.wr = 1; e.val = npc; e.pcn = pc + imm; end
            7'h67: begin e.wr = 1; e.val = npc; e.pcn = ea & 32'hFFFF_FFFE; end
            7'h63: begin
                case (f3)
                    3'd0:    taken = (a == b);
                    3'd1:    taken = (a != b);
                    3'd4:    taken = ($signed(a) < $signed(b));
                    3'd5:    taken = ($signed(a) >= $signed(b));
                    3'd6:    taken = (a < b);
                    default: taken = (a >= b);
                endcase
                if (taken) e.pcn = pc + imm;
            end
            7'h03, 7'h23: begin
                if ((int'(off) % sz) != 0) begin
                    e.exc = 2'd2;
                end else begin
                    e.mem  = 1;
                    e.st   = (ir[6:0] == 7'h23);
                    e.addr = ea - {30'b0, off};
                    e.cyc  = (d >= int'(TMO)) ? int'(TMO) : d + 1;
                    if (e.st) begin
                        if (sz == 1) begin
                            e.be = 4'b0001 << off;   e.wdata = {24'b0, b[7:0]} * 32'h0101_0101;
                        end else if (sz == 2) begin
                            e.be = (off == 2'd2) ? 4'b1100 : 4'b0011;
                            e.wdata = {16'b0, b[15:0]} * 32'h0001_0001;
                        end else begin
                            e.be = 4'b1111; e.wdata = b;
                        end
                    end else begin
                        e.wr = 1;
                        raw  = rdata >> (8 * int'(off));
                        case (f3)
                            3'd0:    e.val = raw[7]  ? ((raw & 32'hFF) | 32'hFFFF_FF00) : (raw & 32'hFF);
                            3'd1:    e.val = raw[15] ? ((raw & 32'hFFFF) | 32'hFFFF_0000) : (raw & 32'hFFFF);
                            3'd4:    e.val = raw & 32'hFF;
                            3'd5:    e.val = raw & 32'hFFFF;
                            default: e.val = raw;
                        endcase
                    end
                    if (d >= int'(TMO)) begin
                        e.exc = 2'd3;
                        e.wr  = 0;
                    end
                end
            end
            default: e.exc = 2'd1;
        endcase
        if (e.exc != 2'd0 || e.rd == 5'd0) e.wr = 0;
        return e;
    endfunction

    // Entered and left on a falling edge; d = MEM cycle (0-based) in which DM_ACK is given
    task automatic run_instr(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                             input logic [31:0] ir, input logic [31:0] pc, input int d,
                             input logic [31:0] rdata);
        exp_t e;
        int   n;
        e = model(a, b, imm, ir, pc, d, rdata);
        n = 0;
        while (ID_EX_READY !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (ID_EX_READY !== 1'b1) check_val("ready_wait", 32'(ID_EX_READY), 32'd1);
        ID_EX_A = a; ID_EX_B = b; ID_EX_IMM = imm; ID_EX_IR = ir;
        ID_EX_PC = pc; ID_EX_NPC = pc + 32'd4; ID_EX_VALID = 1'b1;
        @(negedge clk);
        ID_EX_VALID = 1'b0;
        ID_EX_A = $urandom; ID_EX_B = $urandom; ID_EX_IMM = $urandom;
        ID_EX_IR = $urandom; ID_EX_PC = $urandom; ID_EX_NPC = $urandom;
        DM_ACK = 1'($urandom_range(0, 1)); DM_RDATA = $urandom;
        check_val("exec_ready", 32'(ID_EX_READY), 32'd0);
        check_val("exec_req", 32'(DM_REQ), 32'd0);
        check_val("exec_pcv", 32'(PC_NEXT_VALID), 32'd0);
        for (int k = 0; k < e.cyc; k++) begin
            @(negedge clk);
            DM_ACK = 1'b0; DM_RDATA = $urandom;
            check_val("mem_req", 32'(DM_REQ), 32'd1);
            check_val("mem_addr", DM_ADDR, e.addr);
            check_val("mem_we", 32'(DM_WE), 32'(e.st));
            if (e.st) begin
                check_val("mem_be", 32'(DM_BE), 32'(e.be));
                check_val("mem_wdata", DM_WDATA, e.wdata);
            end
            if (k == d) begin
                DM_ACK = 1'b1; DM_RDATA = rdata;
            end
        end
        @(negedge clk);
        DM_ACK = 1'($urandom_range(0, 1)); DM_RDATA = $urandom;
        check_val("wb_pcv", 32'(PC_NEXT_VALID), 32'd1);
        check_val("wb_exc", 32'(EXC), 32'(e.exc));
        check_val("wb_pc", PC_NEXT, e.pcn);
        check_val("wb_we", 32'(WB_WE), 32'(e.wr));
        check_val("wb_req", 32'(DM_REQ), 32'd0);
        if (e.wr) begin
            check_val("wb_rd", 32'(WB_RW_addr), 32'(e.rd));
            check_val("wb_data", WB_WR1, e.val);
        end
        @(negedge clk);
        DM_ACK = 1'b0;
        check_val("post_pcv", 32'(PC_NEXT_VALID), 32'd0);
        check_val("post_we", 32'(WB_WE), 32'd0);
        check_val("post_exc", 32'(EXC), 32'd0);
        check_val("post_ready", 32'(ID_EX_READY), 32'd1);
        check_val("post_pc_hold", PC_NEXT, e.pcn);
    endtask

    initial begin
        logic [31:0] ra, rb, rimm, rir, rpc;
        logic [2:0]  f3;
        logic [6:0]  op;
        int          kind, x, d;

        rst = 1'b0; ID_EX_VALID = 1'b0; DM_ACK = 1'b0; DM_RDATA = '0;
        ID_EX_A = '0; ID_EX_B = '0; ID_EX_IMM = '0; ID_EX_IR = '0; ID_EX_PC = '0; ID_EX_NPC = '0;
        repeat (3) @(negedge clk);
        check_val("rst_ready", 32'(ID_EX_READY), 32'd0);
        check_val("rst_req", 32'(DM_REQ), 32'd0);
        check_val("rst_dm_we", 32'(DM_WE), 32'd0);
        check_val("rst_addr", DM_ADDR, 32'd0);
        check_val("rst_be", 32'(DM_BE), 32'd0);
        check_val("rst_wdata", DM_WDATA, 32'd0);
        check_val("rst_wb_we", 32'(WB_WE), 32'd0);
        check_val("rst_rd", 32'(WB_RW_addr), 32'd0);
        check_val("rst_wr1", WB_WR1, 32'd0);
        check_val("rst_pc", PC_NEXT, 32'd0);
        check_val("rst_pcv", 32'(PC_NEXT_VALID), 32'd0);
        check_val("rst_exc", 32'(EXC), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_val("first_ready", 32'(ID_EX_READY), 32'd1);

        // Directed cases
        run_instr(32'hFFFF_FFFF, 32'd2, 32'd0, 32'h0000_02B3, 32'h40, 0, 32'd0);        // ADD x5
        run_instr(32'd7, 32'd7, 32'hFFFF_FFF0, 32'h0000_0063, 32'h100, 0, 32'd0);         // BEQ taken
        run_instr(32'd7, 32'd8, 32'hFFFF_FFF0, 32'h0000_0063, 32'h100, 0, 32'd0);         // BEQ not taken
        run_instr(32'h200, 32'd0, 32'd3, 32'h0000_0383, 32'h300, 2, 32'h80FF_FFFF);       // LB
        run_instr(32'h1001, 32'hAB, 32'd0, 32'h0000_0023, 32'h304, 1, 32'd0);             // SB
        run_instr(32'd5, 32'd0, 32'd7, 32'h0000_0013, 32'h308, 0, 32'd0);                 // ADDI x0
        run_instr(32'h100, 32'd0, 32'd2, 32'h0000_2183, 32'h30C, 0, 32'd0);               // LW misaligned
        run_instr(32'd1, 32'd2, 32'd3, 32'h0000_007F, 32'h310, 0, 32'd0);                 // illegal
        run_instr(32'h400, 32'd0, 32'd0, 32'h0000_2183, 32'h314, 50, 32'd0);              // LW timeout
        run_instr(32'h400, 32'd0, 32'd0, 32'h0000_2183, 32'h318, 0, 32'h1234_5678);       // LW ack at once

        // Randomized instruction mix
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 11);
            ra   = $urandom;
            rb   = $urandom;
            rimm = $urandom;
            rpc  = $urandom & 32'hFFFF_FFFC;
            rir  = $urandom;
            f3   = 3'($urandom_range(0, 7));
            d    = $urandom_range(0, 6);
            case (kind)
                0:  op = 7'h33;
                1:  op = 7'h13;
                2:  op = 7'h37;
                3:  op = 7'h17;
                4:  op = 7'h6F;
                5:  begin op = 7'h67; f3 = 3'd0; end
                6:  begin
                    op = 7'h63;
                    x  = $urandom_range(0, 5);
                    f3 = 3'((x < 2) ? x : x + 2);
                    if ($urandom_range(0, 2) == 0) rb = ra;
                end
                7, 8: begin
                    op   = 7'h03;
                    x    = $urandom_range(0, 4);
                    f3   = 3'((x < 3) ? x : x + 1);
                    rimm = 32'($urandom_range(0, 15)) - 32'd8;
                end
                9, 10: begin
                    op   = 7'h23;
                    f3   = 3'($urandom_range(0, 2));
                    rimm = 32'($urandom_range(0, 15)) - 32'd8;
                end
                default: begin
                    x = $urandom_range(0, 3);
                    op = (x == 0) ? 7'h7F : ((x == 1) ? 7'h0B : ((x == 2) ? 7'h5B : 7'h00));
                end
            endcase
            rir[6:0]   = op;
            rir[14:12] = f3;
            run_instr(ra, rb, rimm, rir, rpc, d, $urandom);
        end

        // Reset while a load is waiting for its acknowledge
        ID_EX_A = 32'h400; ID_EX_B = '0; ID_EX_IMM = '0; ID_EX_IR = 32'h0000_2183;
        ID_EX_PC = 32'h500; ID_EX_NPC = 32'h504; ID_EX_VALID = 1'b1;
        @(negedge clk);
        ID_EX_VALID = 1'b0;
        @(negedge clk);
        check_val("abort_req_before", 32'(DM_REQ), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("abort_req", 32'(DM_REQ), 32'd0);
        check_val("abort_ready", 32'(ID_EX_READY), 32'd0);
        check_val("abort_pcv", 32'(PC_NEXT_VALID), 32'd0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("release_ready", 32'(ID_EX_READY), 32'd1);
            check_val("release_pcv", 32'(PC_NEXT_VALID), 32'd0);
            check_val("release_req", 32'(DM_REQ), 32'd0);
        end
        run_instr(32'd10, 32'd3, 32'd0, 32'h4000_0333, 32'h600, 0, 32'd0);              // SUB x6

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
